// File: rtl/ahbl_stream_fifo.sv
// AHB-Lite slave that queues 32-bit words written to DATA and drains them on a valid/ready stream.
// Define AHBL_STREAM_FIFO_WAIT_EN to stall full-FIFO DATA writes instead of dropping them and setting OVF.
module ahbl_stream_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [31:0] S_TDATA,
  output logic        S_TVALID,
  input  logic        S_TREADY,
  output logic        DREQ,
  output logic        IRQ
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         DEPTH_LV   = LW'(DEPTH);
  localparam logic [LW-1:0]         LV_ZERO    = LW'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [8:0]            THRESH_RST = 9'(DEPTH / 2);

  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [7:0]            dp_addr_q, dp_addr_d;
  logic                  en_q, en_d;
  logic                  empty_ie_q, empty_ie_d;
  logic [8:0]            thresh_q, thresh_d;
  logic                  ovf_q, ovf_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];

  logic        full_s, empty_s, wr_s, data_wr_s, ctrl_wr_s, thresh_wr_s;
  logic        flush_s, ovf_clr_s, push_s, pop_s, overflow_s, hreadyout_s, s_tvalid_s;
  logic [9:0]  free_s;
  logic [31:0] status_s, rdata_s;
  logic        unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:8], HTRANS[0]};

  assign full_s      = (level_q == DEPTH_LV);
  assign empty_s     = (level_q == LV_ZERO);
  assign wr_s        = dp_valid_q & dp_write_q;
  assign data_wr_s   = wr_s & (dp_addr_q == 8'h00);
  assign thresh_wr_s = wr_s & (dp_addr_q == 8'h08);
  assign ctrl_wr_s   = wr_s & (dp_addr_q == 8'h0C);
  assign flush_s     = ctrl_wr_s & HWDATA[1];
  assign ovf_clr_s   = ctrl_wr_s & HWDATA[2];
  assign s_tvalid_s  = en_q & ~empty_s;
  // A pop never frees room for a push in the same cycle: push qualifies on the current FULL only.
  assign pop_s       = s_tvalid_s & S_TREADY & ~flush_s;
  assign push_s      = data_wr_s & ~full_s & ~flush_s;

`ifdef AHBL_STREAM_FIFO_WAIT_EN
  assign overflow_s  = 1'b0;
  assign hreadyout_s = ~(data_wr_s & full_s);
`else
  assign overflow_s  = data_wr_s & full_s;
  assign hreadyout_s = 1'b1;
`endif

  assign free_s   = 10'(DEPTH) - 10'(level_q);
  assign status_s = {13'h0000, ovf_q, full_s, empty_s, 7'h00, 9'(level_q)};

  // Address-phase capture; held while the data phase is being stretched.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    if (HREADY) begin
      dp_valid_d = HSEL & HTRANS[1];
      dp_write_d = HWRITE;
      dp_addr_d  = HADDR[7:0];
    end else begin
      dp_valid_d = dp_valid_q;
    end
  end

  // Control registers, overflow flag and FIFO pointer/storage next state.
  always_comb begin
    en_d       = en_q;
    empty_ie_d = empty_ie_q;
    thresh_d   = thresh_q;
    ovf_d      = ovf_q;
    level_d    = level_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;
    if (ctrl_wr_s) begin
      en_d       = HWDATA[0];
      empty_ie_d = HWDATA[3];
    end else begin
      en_d = en_q;
    end
    if (thresh_wr_s) begin
      thresh_d = HWDATA[8:0];
    end else begin
      thresh_d = thresh_q;
    end
    // An overflow in the same cycle as OVF_CLR wins.
    if (flush_s) begin
      ovf_d = 1'b0;
    end else if (overflow_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (flush_s) begin
      level_d  = LV_ZERO;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
    end else begin
      level_d = level_q + LW'(push_s) - LW'(pop_s);
      if (push_s) begin
        mem_d[wr_ptr_q] = HWDATA;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Read-data mux, driven during the data phase from current register state.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (dp_valid_q & ~dp_write_q) begin
      case (dp_addr_q)
        8'h00:   rdata_s = 32'h0000_0000;
        8'h04:   rdata_s = status_s;
        8'h08:   rdata_s = {23'h000000, thresh_q};
        8'h0C:   rdata_s = {28'h0000000, empty_ie_q, 2'b00, en_q};
        default: rdata_s = 32'hDEAD_BEEF;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 8'h00;
      en_q       <= 1'b0;
      empty_ie_q <= 1'b0;
      thresh_q   <= THRESH_RST;
      ovf_q      <= 1'b0;
      level_q    <= LV_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      en_q       <= en_d;
      empty_ie_q <= empty_ie_d;
      thresh_q   <= thresh_d;
      ovf_q      <= ovf_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_q      <= mem_d;
    end
  end

  assign HREADYOUT = hreadyout_s;
  assign HRDATA    = rdata_s;
  assign S_TDATA   = mem_q[rd_ptr_q];
  assign S_TVALID  = s_tvalid_s;
  assign DREQ      = en_q & (thresh_q != 9'h000) & (free_s >= {1'b0, thresh_q});
  assign IRQ       = ovf_q | (empty_ie_q & en_q & empty_s);

endmodule

// File: tb/tb_ahbl_stream_fifo.sv
// Directed bench for ahbl_stream_fifo: vector table for register/push behaviour plus hand sequences.
module tb_ahbl_stream_fifo;

  logic        HCLK, HRESETn, HSEL, HWRITE, S_TREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, S_TVALID, DREQ, IRQ;
  logic [31:0] HRDATA, S_TDATA;

  ahbl_stream_fifo #(.DEPTH_LOG2(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADYOUT), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .S_TDATA(S_TDATA), .S_TVALID(S_TVALID),
    .S_TREADY(S_TREADY), .DREQ(DREQ), .IRQ(IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_dreq;
    logic        exp_tvalid;
    logic [31:0] exp_tdata;
    logic        exp_irq;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] expq[$];
  logic [31:0] model[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;
  logic        rand_en = 1'b0;
  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic add_v(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic dq, input logic tv,
                       input logic [31:0] td, input logic irq);
    vec_t v;
    v = '{wr, addr, wdata, exp_rd, dq, tv, td, irq};
    vq.push_back(v);
  endtask

  // One non-pipelined transfer; returns at the negedge of the last data-phase cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    int n;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = {24'h000000, addr};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
    @(negedge HCLK);
    n = 0;
    while (HREADYOUT !== 1'b1 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 200) chk("xfer_timeout", HREADYOUT, 32'd1);
    rdata = HRDATA;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      xfer(vq[i].wr, vq[i].addr, vq[i].wdata, rd);
      if (!vq[i].wr) chk($sformatf("v%0d_rdata", i), rd, vq[i].exp_rd);
      chk($sformatf("v%0d_dreq", i), DREQ, 32'(vq[i].exp_dreq));
      chk($sformatf("v%0d_tvalid", i), S_TVALID, 32'(vq[i].exp_tvalid));
      chk($sformatf("v%0d_irq", i), IRQ, 32'(vq[i].exp_irq));
      if (vq[i].exp_tvalid) chk($sformatf("v%0d_tdata", i), S_TDATA, vq[i].exp_tdata);
    end
  endtask

  // Drains expq with S_TREADY held high, one word per cycle, then expects an empty stream.
  task automatic drain_expect(input string name);
    @(posedge HCLK); #1;
    S_TREADY = 1'b1;
    while (expq.size() > 0) begin
      @(negedge HCLK);
      chk({name, "_valid"}, S_TVALID, 32'd1);
      chk({name, "_data"}, S_TDATA, expq.pop_front());
    end
    @(negedge HCLK);
    chk({name, "_empty"}, S_TVALID, 32'd0);
    S_TREADY = 1'b0;
  endtask

  // Scoreboard monitor for the random-ready phase.
  always @(negedge HCLK) begin
    if (mon_en && S_TVALID && S_TREADY) begin
      if (model.size() == 0) chk("mon_extra_pop", S_TVALID, 32'd0);
      else chk("mon_order", S_TDATA, model.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge HCLK); #1;
      if (rand_en) S_TREADY = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'h0; S_TREADY = 1'b0;

    // Reset values, enable, three pushes with stream stalled.
    add_v(1'b0, 8'h0C, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    add_v(1'b0, 8'h08, 32'h0, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 1'b0);
    add_v(1'b0, 8'h04, 32'h0, 32'h0001_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    add_v(1'b0, 8'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    add_v(1'b0, 8'h00, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    add_v(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    add_v(1'b0, 8'h0C, 32'h0, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 1'b0);
    add_v(1'b1, 8'h00, 32'h11, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    add_v(1'b1, 8'h00, 32'h22, 32'h0, 1'b1, 1'b1, 32'h11, 1'b0);
    add_v(1'b1, 8'h00, 32'h33, 32'h0, 1'b1, 1'b1, 32'h11, 1'b0);
    add_v(1'b0, 8'h04, 32'h0, 32'h0000_0003, 1'b1, 1'b1, 32'h11, 1'b0);
    // DREQ threshold: THRESH=4, push 13 words.
    add_v(1'b1, 8'h0C, 32'h1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    add_v(1'b1, 8'h08, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    add_v(1'b0, 8'h08, 32'h0, 32'h0000_0004, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++)
      add_v(1'b1, 8'h00, 32'h100 + 32'(i), 32'h0, 1'b1, (i > 0), 32'h100, 1'b0);
    add_v(1'b0, 8'h04, 32'h0, 32'h0000_000C, 1'b1, 1'b1, 32'h100, 1'b0);
    add_v(1'b1, 8'h00, 32'h10C, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0);
    add_v(1'b0, 8'h04, 32'h0, 32'h0000_000D, 1'b0, 1'b1, 32'h100, 1'b0);
    add_v(1'b1, 8'h08, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
    add_v(1'b0, 8'h08, 32'h0, 32'h0000_0000, 1'b0, 1'b1, 32'h100, 1'b0);

    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("reset_hreadyout", HREADYOUT, 32'd1);

    run_vectors(0, 10);
    expq = '{32'h11, 32'h22, 32'h33};
    drain_expect("drain3");
    xfer(1'b1, 8'h0C, 32'h9, rd);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("empty_status", rd, 32'h0001_0000);
    chk("empty_irq", IRQ, 32'd1);
    run_vectors(11, vq.size() - 1);

    // Fill to 16 and write once more while full.
    for (int i = 13; i < 16; i++) xfer(1'b1, 8'h00, 32'h100 + 32'(i), rd);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("full_status", rd, 32'h0002_0010);
`ifdef AHBL_STREAM_FIFO_WAIT_EN
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk($sformatf("stall%0d_hreadyout", k), HREADYOUT, 32'd0);
    end
    @(posedge HCLK); #1; S_TREADY = 1'b1;
    @(negedge HCLK);
    chk("stall_pop_hreadyout", HREADYOUT, 32'd0);
    @(posedge HCLK); #1; S_TREADY = 1'b0;
    @(negedge HCLK);
    chk("stall_release_hreadyout", HREADYOUT, 32'd1);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("stall_status", rd, 32'h0002_0010);
    for (int i = 1; i < 16; i++) expq.push_back(32'h100 + 32'(i));
    expq.push_back(32'hAA);
`else
    xfer(1'b1, 8'h00, 32'hAA, rd);
    chk("ovf_hreadyout", HREADYOUT, 32'd1);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("ovf_status", rd, 32'h0006_0010);
    chk("ovf_irq", IRQ, 32'd1);
    xfer(1'b1, 8'h0C, 32'h5, rd);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("ovf_clr_status", rd, 32'h0002_0010);
    chk("ovf_clr_irq", IRQ, 32'd0);
    for (int i = 0; i < 16; i++) expq.push_back(32'h100 + 32'(i));
`endif
    drain_expect("drain_full");

    // 40 words with random S_TREADY to wrap the pointers.
    mon_en = 1'b1;
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      model.push_back(32'h300 + 32'(i));
      xfer(1'b1, 8'h00, 32'h300 + 32'(i), rd);
    end
    rand_en = 1'b0;
    @(posedge HCLK); #1; S_TREADY = 1'b1;
    for (int k = 0; k < 64 && S_TVALID; k++) @(negedge HCLK);
    S_TREADY = 1'b0;
    mon_en = 1'b0;
    chk("rand_all_popped", 32'(model.size()), 32'd0);

    // Flush with LEVEL=5 and a pop offered in the flush cycle.
    for (int i = 0; i < 5; i++) xfer(1'b1, 8'h00, 32'h200 + 32'(i), rd);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("preflush_status", rd, 32'h0000_0005);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h3; S_TREADY = 1'b1;
    @(negedge HCLK);
    chk("flush_pop_offered", S_TVALID, 32'd1);
    @(posedge HCLK); #1; S_TREADY = 1'b0;
    @(negedge HCLK);
    chk("flush_tvalid", S_TVALID, 32'd0);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("flush_status", rd, 32'h0001_0000);
    chk("thresh0_dreq", DREQ, 32'd0);
    xfer(1'b1, 8'h08, 32'h8, rd);
    xfer(1'b0, 8'h0C, 32'h0, rd);
    chk("ctrl_flush_reads0", rd, 32'h0000_0001);
    chk("thresh8_dreq", DREQ, 32'd1);
    xfer(1'b1, 8'h00, 32'h77, rd);
    xfer(1'b0, 8'h04, 32'h0, rd);
    chk("postflush_status", rd, 32'h0000_0001);
    chk("postflush_tdata", S_TDATA, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
